// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   XLEN       : address/data width of the fetch path
//   NOP_INST   : instruction returned for fetches beyond the instruction memory
//   fq_entry_t : one fetch-queue entry, {pc, inst}
//   word_align : clears the byte-offset bits of an address
package if_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } fq_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_fq_if.sv
// Bundle of the fetch stage's redirect, ID handshake and program-load signals.
//   master : redirect source / ID stage / loader side (drives redirect, id_ready, imem_*)
//   slave  : the fetch stage (drives inst_valid, pc_id, inst_id, misalign_err)
interface if_stage_fq_if #(
   parameter int unsigned IMEM_DEPTH = 1024
);
   import if_pkg::*;

   localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);

   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              id_ready;
   logic              inst_valid;
   logic [XLEN-1:0]   pc_id;
   logic [31:0]       inst_id;
   logic              misalign_err;
   logic              imem_we;
   logic [ImemAw-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport master (
      output redirect_valid, redirect_pc, id_ready, imem_we, imem_waddr, imem_wdata,
      input  inst_valid, pc_id, inst_id, misalign_err
   );

   modport slave (
      input  redirect_valid, redirect_pc, id_ready, imem_we, imem_waddr, imem_wdata,
      output inst_valid, pc_id, inst_id, misalign_err
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch-queue entries with flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the queue; overrides push and pop that cycle
//   push_i/data_i : enqueue request and entry
//   pop_i         : dequeue request (ignored when empty)
//   data_o        : head entry (undefined when empty)
//   count_o       : number of valid entries, 0..Depth
//   full_o/empty_o: occupancy flags
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  fq_entry_t                data_i,
   input  logic                     pop_i,
   output fq_entry_t                data_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   fq_entry_t       mem_q [Depth];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   // A push into a full queue is only accepted when the head leaves the same cycle.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok)  rptr_d = rptr_q + 1'b1;
         count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; the count alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/if_stage_fq.sv
// RV32I instruction-fetch stage: synchronous-read IMEM with a program-load port,
// a fetch queue with valid/ready handshake to ID, redirect/flush and
// misaligned-target detection.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   bus_io.slave : redirect_valid/redirect_pc in, id_ready in,
//                  inst_valid/pc_id/inst_id out (queue head), misalign_err out,
//                  imem_we/imem_waddr/imem_wdata program-load in
module if_stage_fq
   import if_pkg::*;
#(
   parameter int unsigned     IMEM_DEPTH = 1024,
   parameter int unsigned     FQ_DEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   if_stage_fq_if.slave bus_io
);

   localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);
   localparam int unsigned CntW   = $clog2(FQ_DEPTH) + 1;

   logic [31:0]      imem [IMEM_DEPTH];
   logic [31:0]      rdata_q;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic             inflight_vld_q, inflight_vld_d;
   logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
   logic             misalign_q, misalign_d;

   logic [XLEN-3:0]  word_idx;
   logic             in_range;
   logic             redirect;
   logic             deq;
   logic             issue;
   logic [CntW:0]    occupancy;

   fq_entry_t        fifo_in;
   fq_entry_t        fifo_head;
   logic [CntW-1:0]  fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   assign redirect = bus_io.redirect_valid;
   assign word_idx = fetch_pc_q[XLEN-1:2];
   assign in_range = ({2'b00, word_idx} < IMEM_DEPTH);

   // Read-before-write: a same-edge write to the word being read returns old data.
   always_ff @(posedge clk_i) begin
      if (bus_io.imem_we) begin
         imem[bus_io.imem_waddr] <= bus_io.imem_wdata;
      end
      rdata_q <= in_range ? imem[word_idx[ImemAw-1:0]] : NOP_INST;
   end

   assign deq = !fifo_empty && bus_io.id_ready;

   // Slots already committed after this edge: queued entries, the entry in
   // flight, minus the head leaving now. A new issue needs one more free slot.
   always_comb begin
      occupancy = {1'b0, fifo_count} + (CntW + 1)'(inflight_vld_q) - (CntW + 1)'(deq);
      issue     = !redirect && (occupancy < (CntW + 1)'(FQ_DEPTH));
   end

   always_comb begin
      fetch_pc_d     = fetch_pc_q;
      inflight_vld_d = 1'b0;
      inflight_pc_d  = inflight_pc_q;
      misalign_d     = 1'b0;
      if (redirect) begin
         fetch_pc_d = word_align(bus_io.redirect_pc);
         misalign_d = (bus_io.redirect_pc[1:0] != 2'b00);
      end else if (issue) begin
         fetch_pc_d     = fetch_pc_q + XLEN'(4);
         inflight_vld_d = 1'b1;
         inflight_pc_d  = fetch_pc_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q     <= RESET_PC;
         inflight_vld_q <= 1'b0;
         inflight_pc_q  <= '0;
         misalign_q     <= 1'b0;
      end else begin
         fetch_pc_q     <= fetch_pc_d;
         inflight_vld_q <= inflight_vld_d;
         inflight_pc_q  <= inflight_pc_d;
         misalign_q     <= misalign_d;
      end
   end

   assign fifo_in = '{pc: inflight_pc_q, inst: rdata_q};

   // Flush on redirect also drops the in-flight entry that would enqueue this edge.
   fetch_fifo #(
      .Depth (FQ_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect),
      .push_i  (inflight_vld_q),
      .data_i  (fifo_in),
      .pop_i   (deq),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Outputs read zero while the queue is empty so reset/flush leave no stale head.
   assign bus_io.inst_valid   = !fifo_empty;
   assign bus_io.pc_id        = fifo_empty ? '0 : fifo_head.pc;
   assign bus_io.inst_id      = fifo_empty ? '0 : fifo_head.inst;
   assign bus_io.misalign_err = misalign_q;

   // The reserved in-flight slot means an enqueue never meets a full queue.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_full && inflight_vld_q && !deq && !redirect));

endmodule

// File: tb/tb_if_stage_fq.sv
// Directed self-checking bench for if_stage_fq.
module tb_if_stage_fq;
   import if_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_stage_fq_if #(.IMEM_DEPTH(1024)) bus ();

   if_stage_fq #(
      .IMEM_DEPTH (1024),
      .FQ_DEPTH   (4),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model [64];
   logic [31:0] exp_pc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      if (pc[31:2] >= 30'd1024) return NOP_INST;
      return model[pc[7:2]];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects a valid head each cycle with consecutive PCs from exp_pc, id_ready high.
   task automatic drain(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd1);
         check_eq({tag, "_pc"}, bus.pc_id, exp_pc);
         check_eq({tag, "_inst"}, bus.inst_id, exp_inst(exp_pc));
         exp_pc = exp_pc + 32'd4;
         tick();
      end
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      tick();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
   endtask

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b0;
      bus.imem_we        = 1'b0;
      bus.imem_waddr     = '0;
      bus.imem_wdata     = '0;

      // Program load while held in reset.
      bus.imem_we = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bus.imem_waddr = 10'(i);
         bus.imem_wdata = 32'hA000_0000 + 32'(i);
         model[i]       = 32'hA000_0000 + 32'(i);
         tick();
      end
      bus.imem_we = 1'b0;

      check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("rst_pc", bus.pc_id, 32'd0);
      check_eq("rst_inst", bus.inst_id, 32'd0);
      check_eq("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);

      // Reset release: first valid after the second edge.
      bus.id_ready = 1'b1;
      rst_n = 1'b1;
      check_eq("lat_e0", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      check_eq("lat_e1", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      exp_pc = 32'd0;
      drain(8, "stream");

      // Stall: queue fills to 4 and issue stops.
      bus.id_ready = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_eq("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      check_eq("stall_pc", bus.pc_id, exp_pc);
      check_eq("stall_count", 32'(dut.u_fifo.count_o), 32'd4);
      check_eq("stall_inflight", {31'd0, dut.inflight_vld_q}, 32'd0);
      bus.id_ready = 1'b1;
      drain(10, "release");

      // Redirect with 3 queued and one in flight.
      check_eq("pre_redir_count", 32'(dut.u_fifo.count_o), 32'd3);
      check_eq("pre_redir_infl", {31'd0, dut.inflight_vld_q}, 32'd1);
      redirect_to(32'h0000_0040);
      check_eq("redir_e0_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("redir_misalign", {31'd0, bus.misalign_err}, 32'd0);
      tick();
      check_eq("redir_e1_valid", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      exp_pc = 32'h0000_0040;
      drain(4, "redir");

      // Misaligned target.
      redirect_to(32'h0000_0042);
      check_eq("mis_pulse", {31'd0, bus.misalign_err}, 32'd1);
      check_eq("mis_e0_valid", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      check_eq("mis_clear", {31'd0, bus.misalign_err}, 32'd0);
      tick();
      exp_pc = 32'h0000_0040;
      drain(2, "mis");

      // Beyond memory: NOP.
      redirect_to(32'h0000_1000);
      tick();
      tick();
      exp_pc = 32'h0000_1000;
      drain(3, "oob");
      check_eq("oob_nop_const", bus.inst_id, 32'h0000_0013);

      // Same-cycle write to word 5 while fetching PC 0x14.
      redirect_to(32'h0000_0014);
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 10'd5;
      bus.imem_wdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_we = 1'b0;
      tick();
      check_eq("rdw_valid", {31'd0, bus.inst_valid}, 32'd1);
      check_eq("rdw_pc", bus.pc_id, 32'h0000_0014);
      check_eq("rdw_old", bus.inst_id, 32'hA000_0005);
      model[5] = 32'hDEAD_BEEF;
      redirect_to(32'h0000_0014);
      tick();
      tick();
      exp_pc = 32'h0000_0014;
      drain(2, "refetch");

      // Asynchronous reset mid-stream.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("arst_pc", bus.pc_id, 32'd0);
      check_eq("arst_inst", bus.inst_id, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("rest_e0", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      check_eq("rest_e1", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      exp_pc = 32'd0;
      drain(4, "restart");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
